// File: rtl/miner_ctrl.sv
// Nonce-issue controller for a hashing pipeline: paces nonces into the W-schedule
// stage, watches the comparator for a hit, and waits for the pipeline to drain.
module miner_ctrl #(
   parameter int unsigned DELAY     = 32,
   parameter int unsigned DRAIN_LAT = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] nonce_start,
   input  logic [31:0] nonce_end,
   input  logic        found_valid,
   input  logic [31:0] found_nonce,
   output logic        issue_en,
   output logic [31:0] issue_nonce,
   output logic        busy,
   output logic        done,
   output logic        result_valid,
   output logic [31:0] result_nonce,
   output logic [31:0] issue_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DRAIN
   } state_t;

   // The ISSUE cycle itself plus the cycle after the gap reaches zero make up
   // the two cycles not covered by the loaded count.
   localparam logic [7:0] GAP_LOAD   = 8'(DELAY - 2);
   localparam logic [9:0] DRAIN_LOAD = 10'(DRAIN_LAT - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_cur;
   logic [31:0] r_last;
   logic [7:0]  r_gap;
   logic [9:0]  r_drain;
   logic [31:0] r_issue_nonce;
   logic        r_result_valid;
   logic [31:0] r_result_nonce;
   logic [31:0] r_issue_count;
   logic        w_hit;
   logic        w_done;

   // Abort outranks a hit so the result registers hold on the abort cycle.
   assign w_hit = found_valid && !r_result_valid && (r_state != S_IDLE) && !abort;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (abort)                          w_next_state = S_IDLE;
            else if (w_hit || (r_cur == r_last)) w_next_state = S_DRAIN;
            else                                 w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (abort)             w_next_state = S_IDLE;
            else if (w_hit)        w_next_state = S_DRAIN;
            else if (r_gap == '0)  w_next_state = S_ISSUE;
         end
         S_DRAIN: begin
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (r_drain == '0) begin
               w_next_state = S_IDLE;
               w_done       = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cur          <= '0;
         r_last         <= '0;
         r_gap          <= '0;
         r_drain        <= '0;
         r_issue_nonce  <= '0;
         r_result_valid <= 1'b0;
         r_result_nonce <= '0;
         r_issue_count  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur          <= nonce_start;
                  r_last         <= nonce_end;
                  r_issue_nonce  <= nonce_start;
                  r_result_valid <= 1'b0;
                  r_result_nonce <= '0;
                  r_issue_count  <= '0;
               end
            end
            S_ISSUE: begin
               if (r_issue_count != 32'hFFFF_FFFF) r_issue_count <= r_issue_count + 32'd1;
               r_gap <= GAP_LOAD;
               if (w_next_state == S_DRAIN) r_drain <= DRAIN_LOAD;
               if (w_next_state == S_WAIT)  r_cur   <= r_cur + 32'd1;
            end
            S_WAIT: begin
               if (r_gap != '0) r_gap <= r_gap - 8'd1;
               // issue_nonce is registered on entry to ISSUE so it holds between pulses.
               if (w_next_state == S_ISSUE) r_issue_nonce <= r_cur;
               if (w_next_state == S_DRAIN) r_drain       <= DRAIN_LOAD;
            end
            S_DRAIN: begin
               if (r_drain != '0) r_drain <= r_drain - 10'd1;
            end
            default: ;
         endcase
         if (w_hit) begin
            r_result_valid <= 1'b1;
            r_result_nonce <= found_nonce;
         end
      end
   end

   assign issue_en     = (r_state == S_ISSUE);
   assign issue_nonce  = r_issue_nonce;
   assign busy         = (r_state != S_IDLE);
   assign done         = w_done;
   assign result_valid = r_result_valid;
   assign result_nonce = r_result_nonce;
   assign issue_count  = r_issue_count;

endmodule

// File: tb/tb_miner_ctrl.sv
// Self-checking bench for miner_ctrl (DELAY=4, DRAIN_LAT=3): expected issue times,
// nonces, done timing and results are derived arithmetically per job.
module tb_miner_ctrl;

   localparam int D  = 4;
   localparam int DL = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] nonce_start = '0;
   logic [31:0] nonce_end = '0;
   logic        found_valid = 1'b0;
   logic [31:0] found_nonce = '0;
   logic        issue_en;
   logic [31:0] issue_nonce;
   logic        busy;
   logic        done;
   logic        result_valid;
   logic [31:0] result_nonce;
   logic [31:0] issue_count;

   miner_ctrl #(.DELAY(D), .DRAIN_LAT(DL)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .nonce_start  (nonce_start),
      .nonce_end    (nonce_end),
      .found_valid  (found_valid),
      .found_nonce  (found_nonce),
      .issue_en     (issue_en),
      .issue_nonce  (issue_nonce),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .result_nonce (result_nonce),
      .issue_count  (issue_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_errors = 0;
   int          iss_cyc[$];
   logic [31:0] iss_non[$];
   int          done_q[$];
   int          last_busy = -1;

   // Observation point is the falling edge, half a cycle from the active edge.
   always @(negedge clk) begin
      if (issue_en) begin
         iss_cyc.push_back(cyc);
         iss_non.push_back(issue_nonce);
      end
      if (done) done_q.push_back(cyc);
      if (busy) last_busy = cyc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // mode 0: plain job, 1: hit at cycle t0+idx*D+off (second hit next cycle),
   // 2: abort at cycle t0+idx*D+off.
   task automatic run_job(input logic [31:0] ns, input int n, input int mode,
                          input int idx, input int off, input logic [31:0] hn,
                          input string name);
      int          t0, n_iss, done_c, end_c, th, ta;
      logic        exp_rv;
      logic [31:0] exp_rn;
      logic [31:0] ne;
      ne = ns + 32'(n - 1);
      iss_cyc.delete();
      iss_non.delete();
      done_q.delete();
      next_cycle();
      start       = 1'b1;
      nonce_start = ns;
      nonce_end   = ne;
      t0          = cyc + 1;

      n_iss  = n;
      done_c = t0 + (n - 1) * D + DL;
      exp_rv = 1'b0;
      exp_rn = '0;
      th     = -100;
      ta     = -100;
      if (mode == 1) begin
         th     = t0 + idx * D + off;
         exp_rv = 1'b1;
         exp_rn = hn;
         if (idx < n - 1) begin
            n_iss  = idx + 1;
            done_c = th + DL;
         end
      end
      end_c = done_c;
      if (mode == 2) begin
         ta    = t0 + idx * D + off;
         n_iss = idx + 1;
         end_c = ta;
      end

      while (cyc < end_c + 6) begin
         next_cycle();
         start       = (cyc == t0 + 1);
         if (cyc == t0) begin
            nonce_start = $urandom;
            nonce_end   = $urandom;
         end
         found_valid = (mode == 1) && ((cyc == th) || (cyc == th + 1));
         found_nonce = (cyc == th) ? hn : hn + 32'd1;
         abort       = (mode == 2) && (cyc == ta);
      end
      @(negedge clk);
      #1;

      check({name, ":n_issues"}, 32'(iss_cyc.size()), 32'(n_iss));
      for (int k = 0; k < n_iss && k < iss_cyc.size(); k++) begin
         check($sformatf("%s:issue%0d_cycle", name, k), 32'(iss_cyc[k]), 32'(t0 + k * D));
         check($sformatf("%s:issue%0d_nonce", name, k), iss_non[k], ns + 32'(k));
      end
      check({name, ":n_done"}, 32'(done_q.size()), (mode == 2) ? 32'd0 : 32'd1);
      if (mode != 2 && done_q.size() > 0)
         check({name, ":done_cycle"}, 32'(done_q[0]), 32'(done_c));
      check({name, ":last_busy"}, 32'(last_busy), 32'(end_c));
      check({name, ":busy_after"}, {31'd0, busy}, 32'd0);
      check({name, ":issue_count"}, issue_count, 32'(n_iss));
      check({name, ":result_valid"}, {31'd0, result_valid}, {31'd0, exp_rv});
      check({name, ":result_nonce"}, result_nonce, exp_rn);
      check({name, ":issue_nonce_hold"}, issue_nonce, ns + 32'(n_iss - 1));
   endtask

   task automatic check_all_zero(input string name);
      check({name, ":issue_en"}, {31'd0, issue_en}, 32'd0);
      check({name, ":busy"}, {31'd0, busy}, 32'd0);
      check({name, ":done"}, {31'd0, done}, 32'd0);
      check({name, ":result_valid"}, {31'd0, result_valid}, 32'd0);
      check({name, ":issue_nonce"}, issue_nonce, 32'd0);
      check({name, ":result_nonce"}, result_nonce, 32'd0);
      check({name, ":issue_count"}, issue_count, 32'd0);
   endtask

   initial begin
      int          t0;
      int          n;
      int          mode;
      int          idx;
      logic [31:0] ns;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_init");
      reset = 1'b1;

      // found_valid while idle must not set the result.
      next_cycle();
      found_valid = 1'b1;
      found_nonce = 32'h1234_5678;
      next_cycle();
      found_valid = 1'b0;
      next_cycle();
      check("idle_hit:result_valid", {31'd0, result_valid}, 32'd0);
      check("idle_hit:busy", {31'd0, busy}, 32'd0);

      run_job(32'h10, 3, 0, 0, 0, 0, "basic");
      run_job(32'hFFFF_FFFE, 4, 0, 0, 0, 0, "wrap");
      run_job(32'h0, 10, 1, 4, 1, 32'h3, "hit_wait");
      run_job(32'h100, 5, 2, 1, 2, 0, "abort_wait");
      run_job(32'h20, 6, 1, 1, 2, 32'hA, "two_hits");
      run_job(32'h40, 2, 2, 1, 3, 0, "abort_at_done");
      run_job(32'h50, 2, 1, 1, 2, 32'h51, "hit_drain");
      run_job(32'h60, 1, 0, 0, 0, 0, "single");

      // Reset while draining, then a one-nonce job.
      next_cycle();
      start       = 1'b1;
      nonce_start = 32'h10;
      nonce_end   = 32'h12;
      t0          = cyc + 1;
      next_cycle();
      start = 1'b0;
      while (cyc < t0 + 2 * D + 1) next_cycle();
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("reset_drain");
      repeat (3) next_cycle();
      reset = 1'b1;
      iss_cyc.delete();
      done_q.delete();
      repeat (10) next_cycle();
      check("post_reset:no_issue", 32'(iss_cyc.size()), 32'd0);
      check("post_reset:no_done", 32'(done_q.size()), 32'd0);
      check("post_reset:busy", {31'd0, busy}, 32'd0);
      run_job(32'h7, 1, 0, 0, 0, 0, "after_reset");

      for (int j = 0; j < 12; j++) begin
         n    = int'($urandom_range(1, 5));
         mode = int'($urandom_range(0, 2));
         idx  = int'($urandom_range(0, n - 1));
         ns   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
         run_job(ns, n, mode, idx, int'($urandom_range(1, D - 1)), $urandom,
                 $sformatf("rand%0d", j));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/miner_ctrl.md
MINER_CTRL -- requirements
Module: miner_ctrl

Interface
REQ-001 Parameter DELAY, default 32: cycles between consecutive issue_en pulses; equals the W-schedule stage occupancy; legal range 2..255.
REQ-002 Parameter DRAIN_LAT, default 160: cycles from the last issue_en until results for the last nonce are guaranteed back; legal range 1..1023.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  job start strobe, sampled only in IDLE.
REQ-006 abort  input  1  terminate the current job.
REQ-007 nonce_start  input  32  first nonce of the job.
REQ-008 nonce_end  input  32  last nonce of the job, inclusive.
REQ-009 found_valid  input  1  downstream comparator reports a hit.
REQ-010 found_nonce  input  32  nonce of the hit, qualified by found_valid.
REQ-011 issue_en  output  1  one-cycle enable to the W-schedule stage.
REQ-012 issue_nonce  output  32  nonce accompanying issue_en.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at normal job completion.
REQ-015 result_valid  output  1  sticky hit flag.
REQ-016 result_nonce  output  32  first hit nonce of the job.
REQ-017 issue_count  output  32  number of issue_en pulses in the current job, saturating at 0xFFFFFFFF.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and DRAIN.
REQ-019 In IDLE, start=1 SHALL load cur=nonce_start and last=nonce_end, clear result_valid, result_nonce and issue_count, and enter ISSUE on the next cycle.
REQ-020 In IDLE, start=0 SHALL leave all state unchanged; start in any other state SHALL be ignored.
REQ-021 ISSUE SHALL last one cycle and drive issue_en=1 with issue_nonce=cur.
REQ-022 ISSUE SHALL increment issue_count and load the gap counter with DELAY-2.
REQ-023 From ISSUE, if cur==last the FSM SHALL load the drain counter with DRAIN_LAT-1 and enter DRAIN; otherwise it SHALL set cur=cur+1 mod 2^32 and enter WAIT.
REQ-024 WAIT SHALL decrement the gap counter each cycle and enter ISSUE in the cycle after the counter reads 0, so consecutive issue_en pulses are exactly DELAY cycles apart.
REQ-025 issue_en SHALL never be high in two cycles less than DELAY apart.
REQ-026 DRAIN SHALL decrement the drain counter; when it reads 0 it SHALL pulse done=1 for one cycle and return to IDLE.
REQ-027 Nonce iteration SHALL wrap from 0xFFFFFFFF to 0x00000000; a job SHALL issue ((nonce_end-nonce_start) mod 2^32)+1 nonces, so nonce_start==nonce_end issues exactly one nonce.
REQ-028 found_valid=1 while result_valid=0, in ISSUE, WAIT or DRAIN, SHALL set result_valid=1 and capture found_nonce into result_nonce.
REQ-029 After a hit, further hits SHALL be ignored until the next start.
REQ-030 A hit in ISSUE or WAIT SHALL stop further issuing: the FSM enters DRAIN next cycle with the drain counter at DRAIN_LAT-1; an issue_en in the same cycle as the hit still completes.
REQ-031 found_valid in IDLE SHALL be ignored.
REQ-032 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle with no done pulse and no further issue_en; result_valid, result_nonce and issue_count SHALL hold.
REQ-033 abort takes priority over a simultaneous found_valid, start, or drain completion.
REQ-034 issue_nonce SHALL hold its last value when issue_en=0.

Reset
REQ-035 reset low SHALL immediately force the FSM to IDLE and clear issue_en, busy, done and result_valid.
REQ-036 reset low SHALL also clear issue_nonce, result_nonce, issue_count and all internal counters to zero, regardless of clk.
REQ-037 Reset asserted mid-job SHALL abandon the job with no done pulse; after reset deasserts, no activity SHALL occur until a new start.

Verification (DELAY=4, DRAIN_LAT=3)
REQ-038 start, nonce_start=0x10, nonce_end=0x12 -> issue_en at t0, t0+4, t0+8 with nonces 0x10, 0x11, 0x12; done 3 cycles after t0+8; issue_count=3; result_valid=0.
REQ-039 nonce_start=0xFFFFFFFE, nonce_end=0x00000001 -> issue_nonce sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; issue_count=4.
REQ-040 Range 0x0..0x9, found_valid with found_nonce=0x3 during WAIT after the 5th issue -> no 6th issue; result_nonce=0x3; result_valid=1; done after drain; issue_count=5.
REQ-041 abort two cycles after the 2nd issue -> busy=0 next cycle; no done; issue_count=2; a start pulsed during the job was ignored.
REQ-042 reset low during DRAIN, then start with nonce_start=nonce_end=0x7 -> all outputs zero during reset; one issue of nonce 0x7; done 3 cycles later.
REQ-043 Two hits in one job, 0xA then 0xB -> result_nonce=0xA.
